// File: rtl/csi_pkg.sv
// Shared definitions for the CSI magnitude pipeline: mode encoding and depth.
package csi_pkg;

   typedef enum logic [1:0] {
      MAG_L0   = 2'd0,
      MAG_AMBM = 2'd1,
      MAG_L1   = 2'd2,
      MAG_PWR  = 2'd3
   } mag_mode_e;

   localparam int NUM_STAGES = 3;

endpackage

// File: rtl/csi_mag_pipe_if.sv
// Stream bundle around the magnitude pipeline: I/Q input beats in, magnitude beats out.
interface csi_mag_pipe_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 10
);
   logic signed [DATA_WIDTH-1:0]   i;
   logic signed [DATA_WIDTH-1:0]   q;
   logic                           s_valid;
   logic                           s_last;
   logic                           s_ready;
   logic [1:0]                     mode;
   logic [2*DATA_WIDTH-1:0]        mag;
   logic [IDX_WIDTH-1:0]           idx;
   logic                           m_last;
   logic                           m_valid;
   logic                           m_ready;

   modport master (
      output i, q, s_valid, s_last, mode, m_ready,
      input  s_ready, mag, idx, m_last, m_valid
   );

   modport slave (
      input  i, q, s_valid, s_last, mode, m_ready,
      output s_ready, mag, idx, m_last, m_valid
   );
endinterface

// File: rtl/csi_mag_pipe_core.sv
// Three-stage magnitude datapath: |I|,|Q| -> min/max operands -> final sum.
module csi_mag_pipe_core
   import csi_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 10
) (
   input logic           clk_in,
   input logic           rst_n_in,
   csi_mag_pipe_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int MW = 2 * DATA_WIDTH;

   logic s1_valid, s1_ready, s1_load;
   logic s2_valid, s2_ready, s2_load;
   logic s3_valid, s3_ready, s3_load;

   pipe_stage_ctrl u_s1 (.clk_in, .rst_n_in, .up_valid_in(bus.s_valid), .dn_ready_in(s2_ready),
                         .valid_out(s1_valid), .ready_out(s1_ready), .load_out(s1_load));
   pipe_stage_ctrl u_s2 (.clk_in, .rst_n_in, .up_valid_in(s1_valid), .dn_ready_in(s3_ready),
                         .valid_out(s2_valid), .ready_out(s2_ready), .load_out(s2_load));
   pipe_stage_ctrl u_s3 (.clk_in, .rst_n_in, .up_valid_in(s2_valid), .dn_ready_in(bus.m_ready),
                         .valid_out(s3_valid), .ready_out(s3_ready), .load_out(s3_load));

   assign bus.s_ready = rst_n_in & s1_ready;

   // Mode is captured on the first beat of a frame and reused for the rest of it.
   mag_mode_e            mode_q, beat_mode_d;
   logic                 frame_start_q;
   logic [IDX_WIDTH-1:0] idx_q;

   assign beat_mode_d = frame_start_q ? mag_mode_e'(bus.mode) : mode_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mode_q        <= MAG_L0;
         frame_start_q <= 1'b1;
         idx_q         <= '0;
      end else if (s1_load) begin
         mode_q        <= beat_mode_d;
         frame_start_q <= bus.s_last;
         idx_q         <= bus.s_last ? '0 : idx_q + 1'b1;
      end
   end

   // Two's complement negate keeps -2^(W-1) as 2^(W-1) in an unsigned W-bit field.
   logic [W-1:0] i_u, q_u, abs_i_d, abs_q_d;
   assign i_u     = bus.i;
   assign q_u     = bus.q;
   assign abs_i_d = i_u[W-1] ? (~i_u + 1'b1) : i_u;
   assign abs_q_d = q_u[W-1] ? (~q_u + 1'b1) : q_u;

   logic [W-1:0]         s1_abs_i_q, s1_abs_q_q;
   mag_mode_e            s1_mode_q;
   logic [IDX_WIDTH-1:0] s1_idx_q;
   logic                 s1_last_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_abs_i_q <= '0;
         s1_abs_q_q <= '0;
         s1_mode_q  <= MAG_L0;
         s1_idx_q   <= '0;
         s1_last_q  <= 1'b0;
      end else if (s1_load) begin
         s1_abs_i_q <= abs_i_d;
         s1_abs_q_q <= abs_q_d;
         s1_mode_q  <= beat_mode_d;
         s1_idx_q   <= idx_q;
         s1_last_q  <= bus.s_last;
      end
   end

   logic [W-1:0]  mx_d, mn_d;
   logic [MW-1:0] op_a_d, op_b_d;

   always_comb begin
      mx_d   = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_i_q : s1_abs_q_q;
      mn_d   = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_q_q : s1_abs_i_q;
      op_a_d = MW'(mx_d);
      op_b_d = MW'(mn_d >> 2);
      case (s1_mode_q)
         MAG_AMBM: begin
            op_a_d = MW'(mx_d - (mx_d >> 3));
            op_b_d = MW'(mn_d >> 1);
         end
         MAG_L1: begin
            op_a_d = MW'(s1_abs_i_q);
            op_b_d = MW'(s1_abs_q_q);
         end
         MAG_PWR: begin
            op_a_d = MW'(s1_abs_i_q) * MW'(s1_abs_i_q);
            op_b_d = MW'(s1_abs_q_q) * MW'(s1_abs_q_q);
         end
         default: ;
      endcase
   end

   logic [W-1:0]         s2_mx_q;
   logic [MW-1:0]        s2_op_a_q, s2_op_b_q;
   mag_mode_e            s2_mode_q;
   logic [IDX_WIDTH-1:0] s2_idx_q;
   logic                 s2_last_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s2_mx_q   <= '0;
         s2_op_a_q <= '0;
         s2_op_b_q <= '0;
         s2_mode_q <= MAG_L0;
         s2_idx_q  <= '0;
         s2_last_q <= 1'b0;
      end else if (s2_load) begin
         s2_mx_q   <= mx_d;
         s2_op_a_q <= op_a_d;
         s2_op_b_q <= op_b_d;
         s2_mode_q <= s1_mode_q;
         s2_idx_q  <= s1_idx_q;
         s2_last_q <= s1_last_q;
      end
   end

   // The alpha-max/beta-min estimate is floored at max(|I|,|Q|).
   logic [MW-1:0] sum_d, mag_d;
   assign sum_d = s2_op_a_q + s2_op_b_q;
   assign mag_d = ((s2_mode_q == MAG_AMBM) && (MW'(s2_mx_q) > sum_d)) ? MW'(s2_mx_q) : sum_d;

   logic [MW-1:0]        mag_q;
   logic [IDX_WIDTH-1:0] out_idx_q;
   logic                 out_last_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mag_q      <= '0;
         out_idx_q  <= '0;
         out_last_q <= 1'b0;
      end else if (s3_load) begin
         mag_q      <= mag_d;
         out_idx_q  <= s2_idx_q;
         out_last_q <= s2_last_q;
      end
   end

   assign bus.mag     = mag_q;
   assign bus.idx     = out_idx_q;
   assign bus.m_last  = out_last_q;
   assign bus.m_valid = s3_valid;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/advance bookkeeping for one pipeline stage; a stage moves when empty or
// when the stage after it moves in the same cycle.
module pipe_stage_ctrl (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic up_valid_in,
   input  logic dn_ready_in,
   output logic valid_out,
   output logic ready_out,
   output logic load_out
);
   logic valid_q;

   assign ready_out = ~valid_q | dn_ready_in;
   assign load_out  = up_valid_in & ready_out;
   assign valid_out = valid_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;
      end else if (ready_out) begin
         valid_q <= up_valid_in;
      end
   end
endmodule

// File: rtl/csi_mag_pipe.sv
// Top level: flat stream ports bundled onto the internal interface feeding the core.
module csi_mag_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic signed [DATA_WIDTH-1:0] i_in,
   input  logic signed [DATA_WIDTH-1:0] q_in,
   input  logic                         s_valid_in,
   input  logic                         s_last_in,
   output logic                         s_ready_out,
   input  logic [1:0]                   mode_in,
   output logic [2*DATA_WIDTH-1:0]      mag_out,
   output logic [IDX_WIDTH-1:0]         idx_out,
   output logic                         m_last_out,
   output logic                         m_valid_out,
   input  logic                         m_ready_in
);
   csi_mag_pipe_if #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

   assign bus.i       = i_in;
   assign bus.q       = q_in;
   assign bus.s_valid = s_valid_in;
   assign bus.s_last  = s_last_in;
   assign bus.mode    = mode_in;
   assign bus.m_ready = m_ready_in;

   assign s_ready_out = bus.s_ready;
   assign mag_out     = bus.mag;
   assign idx_out     = bus.idx;
   assign m_last_out  = bus.m_last;
   assign m_valid_out = bus.m_valid;

   csi_mag_pipe_core #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_core (
      .clk_in,
      .rst_n_in,
      .bus (bus)
   );
endmodule

// File: tb/tb_csi_mag_pipe.sv
// Scoreboard bench for csi_mag_pipe: a behavioural model predicts each output beat.
module tb_csi_mag_pipe;
   import csi_pkg::*;

   localparam int DW = 16;
   localparam int IW = 10;
   localparam int MW = 2 * DW;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   csi_mag_pipe_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) tb_bus ();

   csi_mag_pipe #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .i_in        (tb_bus.i),
      .q_in        (tb_bus.q),
      .s_valid_in  (tb_bus.s_valid),
      .s_last_in   (tb_bus.s_last),
      .s_ready_out (tb_bus.s_ready),
      .mode_in     (tb_bus.mode),
      .mag_out     (tb_bus.mag),
      .idx_out     (tb_bus.idx),
      .m_last_out  (tb_bus.m_last),
      .m_valid_out (tb_bus.m_valid),
      .m_ready_in  (tb_bus.m_ready)
   );

   typedef struct packed {
      logic [MW-1:0] mag;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int checks = 0;
   int passed = 0;
   int cyc    = 0;
   int m_frame_start = 1;
   int m_mode = 0;
   int m_idx  = 0;

   always @(posedge clk) cyc++;

   // A beat seen valid&ready at the falling edge transfers on the next rising edge.
   always @(negedge clk)
      if (rst_n && tb_bus.m_valid && tb_bus.m_ready)
         obs_q.push_back({tb_bus.mag, tb_bus.idx, tb_bus.m_last});

   function automatic logic [MW-1:0] model_mag(input int mode, input int i, input int q);
      longint ai = (i < 0) ? -i : i;
      longint aq = (q < 0) ? -q : q;
      longint mx = (ai > aq) ? ai : aq;
      longint mn = (ai > aq) ? aq : ai;
      longint r;
      case (mode)
         0: r = mx + mn / 4;
         1: begin
            r = mx - mx / 8 + mn / 2;
            if (r < mx) r = mx;
         end
         2: r = ai + aq;
         default: r = longint'(i) * i + longint'(q) * q;
      endcase
      return r[MW-1:0];
   endfunction

   task automatic model_reset();
      m_frame_start = 1;
      m_mode = 0;
      m_idx  = 0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic send_beat(input int i, input int q, input logic last, input logic [1:0] mode);
      bit acc = 1'b0;
      beat_t e;
      tb_bus.i       = DW'(i);
      tb_bus.q       = DW'(q);
      tb_bus.s_last  = last;
      tb_bus.mode    = mode;
      tb_bus.s_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = tb_bus.s_ready;
         @(posedge clk);
         #1;
      end
      tb_bus.s_valid = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL accept_timeout beat i=%0d q=%0d never accepted, required acceptance within 200 cycles", i, q);
         return;
      end
      if (m_frame_start != 0) m_mode = mode;
      e.mag  = model_mag(m_mode, i, q);
      e.idx  = IW'(m_idx);
      e.last = last;
      exp_q.push_back(e);
      m_idx = last ? 0 : (m_idx + 1) % (1 << IW);
      m_frame_start = last ? 1 : 0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && obs_q.size() < exp_q.size(); n++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tb_bus.m_ready = 1'b1;
      tb_bus.s_valid = 1'b1;
      tb_bus.s_last  = 1'b0;
      tb_bus.mode    = 2'd0;
      tb_bus.i       = '0;
      tb_bus.q       = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tb_bus.s_ready !== 1'b0) $display("FAIL reset_s_ready got=%b required=0", tb_bus.s_ready); else passed++;
      checks++; if (tb_bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b required=0", tb_bus.m_valid); else passed++;
      checks++; if (tb_bus.mag !== '0) $display("FAIL reset_mag got=%0d required=0", tb_bus.mag); else passed++;
      checks++; if (tb_bus.idx !== '0) $display("FAIL reset_idx got=%0d required=0", tb_bus.idx); else passed++;
      checks++; if (tb_bus.m_last !== 1'b0) $display("FAIL reset_m_last got=%b required=0", tb_bus.m_last); else passed++;
      tb_bus.s_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (tb_bus.s_ready !== 1'b1) $display("FAIL release_s_ready got=%b required=1", tb_bus.s_ready); else passed++;
      model_reset();
   endtask

   task automatic test_l0_latency();
      beat_t e, o;
      tb_bus.m_ready = 1'b1;
      send_beat(-300, 400, 1'b1, 2'd0);
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
         checks++;
         if (tb_bus.m_valid !== 1'b0) $display("FAIL latency_early cycle=%0d m_valid=%b required=0", k, tb_bus.m_valid); else passed++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (tb_bus.m_valid !== 1'b1 || tb_bus.mag !== MW'(475) || tb_bus.idx !== '0)
         $display("FAIL latency_l0 valid=%b mag=%0d idx=%0d required valid=1 mag=475 idx=0", tb_bus.m_valid, tb_bus.mag, tb_bus.idx);
      else passed++;
      wait_drain();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL l0_beat no output, required mag=%0d idx=%0d", e.mag, e.idx);
            continue;
         end
         o = obs_q.pop_front();
         if (o !== e) $display("FAIL l0_beat mag=%0d idx=%0d last=%b required mag=%0d idx=%0d last=%b", o.mag, o.idx, o.last, e.mag, e.idx, e.last);
         else passed++;
      end
   endtask

   task automatic test_corners();
      logic [MW-1:0] lit [4] = '{32'd2147483648, 32'd65536, 32'd128, 32'd100};
      beat_t e, o;
      tb_bus.m_ready = 1'b1;
      send_beat(-32768, -32768, 1'b1, 2'd3);
      send_beat(-32768, -32768, 1'b1, 2'd2);
      send_beat(100, 80, 1'b1, 2'd1);
      send_beat(100, 0, 1'b1, 2'd1);
      wait_drain();
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL corner_beat%0d no output, required mag=%0d", k, lit[k]);
            continue;
         end
         o = obs_q.pop_front();
         if (o.mag !== lit[k] || o !== e)
            $display("FAIL corner_beat%0d mag=%0d idx=%0d last=%b required mag=%0d idx=%0d last=%b", k, o.mag, o.idx, o.last, lit[k], e.idx, e.last);
         else passed++;
      end
   endtask

   task automatic test_stall_frame();
      beat_t e, o;
      tb_bus.m_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 5; k++)
               send_beat(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                         (k == 4), 2'($urandom_range(3)));
         end
         begin
            repeat (40) begin
               @(posedge clk);
               #1 tb_bus.m_ready = ~tb_bus.m_ready;
            end
         end
         begin : stab
            logic prev_stall;
            logic [MW-1:0] pm;
            logic [IW-1:0] pi;
            logic pl;
            prev_stall = 1'b0;
            pm = '0; pi = '0; pl = 1'b0;
            repeat (40) begin
               @(negedge clk);
               if (prev_stall) begin
                  checks++;
                  if (tb_bus.m_valid !== 1'b1 || tb_bus.mag !== pm || tb_bus.idx !== pi || tb_bus.m_last !== pl)
                     $display("FAIL stall_hold valid=%b mag=%0d idx=%0d last=%b required valid=1 mag=%0d idx=%0d last=%b",
                              tb_bus.m_valid, tb_bus.mag, tb_bus.idx, tb_bus.m_last, pm, pi, pl);
                  else passed++;
               end
               prev_stall = tb_bus.m_valid && !tb_bus.m_ready;
               pm = tb_bus.mag;
               pi = tb_bus.idx;
               pl = tb_bus.m_last;
            end
         end
      join
      tb_bus.m_ready = 1'b1;
      wait_drain();
      for (int k = 0; k < 5; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL stall_beat%0d no output, required idx=%0d", k, k);
            continue;
         end
         o = obs_q.pop_front();
         if (o !== e || o.idx !== IW'(k) || o.last !== (k == 4))
            $display("FAIL stall_beat%0d mag=%0d idx=%0d last=%b required mag=%0d idx=%0d last=%b", k, o.mag, o.idx, o.last, e.mag, k, (k == 4));
         else passed++;
      end
      checks++;
      if (obs_q.size() != 0) $display("FAIL stall_extra outputs=%0d required=0", obs_q.size()); else passed++;
   endtask

   task automatic test_mode_latch();
      logic [MW-1:0] lit_mag [6] = '{32'd250000, 32'd74, 32'd5000000, 32'd17154, 32'd475, 32'd79};
      logic [IW-1:0] lit_idx [6] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd1};
      beat_t e, o;
      tb_bus.m_ready = 1'b1;
      send_beat(300, -400, 1'b0, 2'd3);
      send_beat(-5, 7, 1'b0, 2'd3);
      send_beat(1000, 2000, 1'b0, 2'd0);
      send_beat(-123, 45, 1'b1, 2'd0);
      send_beat(300, -400, 1'b0, 2'd0);
      send_beat(77, -9, 1'b1, 2'd3);
      wait_drain();
      for (int k = 0; k < 6; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL mode_beat%0d no output, required mag=%0d", k, lit_mag[k]);
            continue;
         end
         o = obs_q.pop_front();
         if (o.mag !== lit_mag[k] || o.idx !== lit_idx[k] || o !== e)
            $display("FAIL mode_beat%0d mag=%0d idx=%0d required mag=%0d idx=%0d", k, o.mag, o.idx, lit_mag[k], lit_idx[k]);
         else passed++;
      end
   endtask

   task automatic test_midframe_reset();
      beat_t o;
      tb_bus.m_ready = 1'b0;
      send_beat(11, 22, 1'b0, 2'd1);
      send_beat(33, 44, 1'b0, 2'd1);
      send_beat(55, 66, 1'b0, 2'd1);
      checks++;
      if (tb_bus.m_valid !== 1'b1) $display("FAIL inflight_valid got=%b required=1", tb_bus.m_valid); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tb_bus.m_valid !== 1'b0 || tb_bus.s_ready !== 1'b0)
         $display("FAIL async_reset m_valid=%b s_ready=%b required 0 and 0", tb_bus.m_valid, tb_bus.s_ready);
      else passed++;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      tb_bus.m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != 0) $display("FAIL stale_beat outputs=%0d required=0", obs_q.size()); else passed++;
      send_beat(10, -20, 1'b1, 2'd2);
      wait_drain();
      exp_q.delete();
      checks++;
      if (obs_q.size() == 0) $display("FAIL post_reset_beat no output, required mag=30 idx=0");
      else begin
         o = obs_q.pop_front();
         if (o.mag !== MW'(30) || o.idx !== '0 || o.last !== 1'b1)
            $display("FAIL post_reset_beat mag=%0d idx=%0d last=%b required mag=30 idx=0 last=1", o.mag, o.idx, o.last);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 1030;
      int t0;
      beat_t e, o;
      tb_bus.m_ready = 1'b1;
      t0 = cyc;
      for (int k = 0; k < N; k++)
         send_beat(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                   (k == N - 1), 2'($urandom_range(3)));
      checks++;
      if (cyc - t0 != N) $display("FAIL throughput cycles=%0d required=%0d", cyc - t0, N); else passed++;
      wait_drain();
      for (int k = 0; k < N; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            $display("FAIL b2b_beat%0d no output, required mag=%0d idx=%0d", k, e.mag, e.idx);
            continue;
         end
         o = obs_q.pop_front();
         if (o !== e || (k == 1024 && o.idx !== '0))
            $display("FAIL b2b_beat%0d mag=%0d idx=%0d last=%b required mag=%0d idx=%0d last=%b", k, o.mag, o.idx, o.last, e.mag, e.idx, e.last);
         else passed++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tb_bus.s_valid = 1'b0;
      tb_bus.s_last  = 1'b0;
      tb_bus.mode    = 2'd0;
      tb_bus.m_ready = 1'b0;
      tb_bus.i       = '0;
      tb_bus.q       = '0;
      test_reset();
      test_l0_latency();
      test_corners();
      test_stall_frame();
      test_mode_latch();
      test_midframe_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/csi_mag_pipe.md
CSI_MAG_PIPE -- requirements
Module: csi_mag_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed width of each I/Q component.
REQ-002 SHALL have parameter IDX_WIDTH, default 10, width of the subcarrier index counter.
REQ-003 SHALL have ports:
- clk_in  in  1  sole clock; all logic on its rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- i_in, q_in  in  DATA_WIDTH each  signed I and Q samples.
- s_valid_in  in  1  input beat valid.
- s_last_in  in  1  last beat of a CSI frame.
- s_ready_out  out  1  block can accept a beat.
- mode_in  in  2  magnitude mode, sampled at frame start.
- mag_out  out  2*DATA_WIDTH  unsigned result, zero-extended for modes 0-2.
- idx_out  out  IDX_WIDTH  beat index within frame.
- m_last_out  out  1  frame-end flag, aligned with mag_out.
- m_valid_out  out  1  output beat valid.
- m_ready_in  in  1  downstream accepts.

Function
REQ-004 SHALL complete an input transfer when s_valid_in and s_ready_out are both high on a rising edge; an output transfer when m_valid_out and m_ready_in are both high.
REQ-005 SHALL be a 3-stage pipeline: S1 absolute values, S2 min/max and mode operands, S3 final sum. Latency is 3 cycles from input transfer to m_valid_out with no stall.
REQ-006 SHALL sustain one beat per cycle while m_ready_in is high.
REQ-007 SHALL advance a stage when that stage is empty or the following stage advances in the same cycle. s_ready_out = (S1 empty) or (S1 advances). s_ready_out is combinational from m_ready_in.
REQ-008 SHALL hold mag_out, idx_out and m_last_out stable while m_valid_out is high and m_ready_in is low; no beat is dropped or duplicated.
REQ-009 SHALL compute abs as unsigned DATA_WIDTH bits. -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1) without overflow.
REQ-010 SHALL compute, with mx = max(|I|,|Q|) and mn = min(|I|,|Q|):
- mode 0: mx + (mn>>2).
- mode 1: max(mx, mx - (mx>>3) + (mn>>1)).
- mode 2: |I| + |Q|.
- mode 3: I*I + Q*Q (exact, fits 2*DATA_WIDTH unsigned).
REQ-011 SHALL truncate every right shift toward zero. No rounding. No saturation is required.
REQ-012 SHALL latch mode_in on the first input beat of each frame (the first beat after reset or after a beat with s_last_in). Changes to mode_in mid-frame SHALL have no effect until the next frame.
REQ-013 SHALL carry the latched mode with each beat through the pipeline, so frames with different modes may coexist in the pipeline.
REQ-014 SHALL assign idx 0 to the first beat of a frame and increment by 1 per input transfer. It SHALL wrap modulo 2^IDX_WIDTH without error. It SHALL restart at 0 after a beat with s_last_in.
REQ-015 SHALL pass s_last_in to m_last_out aligned with its beat.
REQ-016 SHALL leave all state unchanged on cycles with s_valid_in low, and SHALL not change idx or the latched mode.

Reset
REQ-017 SHALL, while rst_n_in is low, force m_valid_out=0, mag_out=0, idx_out=0, m_last_out=0, all stage valids=0, idx counter=0, latched mode=0, and the frame-start flag set.
REQ-018 SHALL hold s_ready_out low while rst_n_in is low. It SHALL be high in the first cycle after release.
REQ-019 SHALL discard all in-flight beats on a mid-frame reset. The next accepted beat is idx 0 of a new frame.

Structure
REQ-020 SHALL place the mode encoding (enum MAG_L0=0, MAG_AMBM=1, MAG_L1=2, MAG_PWR=3) and the stage-count constant in shared package csi_pkg.
REQ-021 SHALL implement the per-stage valid/advance logic through one reusable sub-module, pipe_stage_ctrl, instantiated three times.

Verification
REQ-022 With DATA_WIDTH=16, mode 0, I=-300, Q=400 and m_ready_in high -> mag_out=475 exactly 3 cycles later, idx_out=0.
REQ-023 With mode 3, I=-32768, Q=-32768 -> mag_out=2147483648. With mode 2 and the same input -> mag_out=65536.
REQ-024 With mode 1, I=100, Q=80 -> mag_out=128. With I=100, Q=0 -> mag_out=100.
REQ-025 Send a 5-beat frame while toggling m_ready_in 0/1 every cycle -> 5 outputs in order with idx 0..4, m_last_out only on idx 4, and outputs stable during stalls.
REQ-026 Set mode_in=3 at frame start, change it to 0 at beat 2, then start a new frame -> all beats of frame 1 use mode 3, and frame 2 uses mode 0 starting at idx 0.
REQ-027 Assert rst_n_in low asynchronously with 3 beats in flight -> m_valid_out drops immediately, no stale beat emerges after release, and the first new beat has idx_out=0.
